div_restoring_seq: RTL and testbench



---
 rtl/div_restoring_seq.sv | 167 ++++++++++++++++
 tb/tb_div_restoring_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_restoring_seq.sv
// ============================================================================
// Module   : div_restoring_seq
// Purpose  : Multi-cycle restoring divider. One shift/subtract/restore step
//            per clock produces Q = A / B and R = A mod B. The subtract uses
//            the A + ~B + 1 form and takes borrow as the inverted carry-out.
//            A start/done handshake launches an operation and reports its
//            result.
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous active-low reset
//            start  - request pulse; A and B are sampled on the same edge
//            A, B   - dividend, divisor (WIDTH bits)
//            busy   - high while the iteration is running
//            done   - one-cycle pulse; Q/R/dz/ovf are valid from then on
//            Q, R   - quotient, remainder
//            dz     - divide-by-zero flag of the last operation
//            ovf    - signed overflow flag (always 0 in the unsigned build)
// Options  : DIV_SIGNED_EN - when defined, A and B are two's complement and
//            the result follows truncating division (R takes the sign of A).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_restoring_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    c_cnt_one  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    c_cnt_init = CW'(WIDTH);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  // The top remainder bit is never needed before a shift: after j < WIDTH
  // steps the partial remainder is below 2**j, so it always fits WIDTH-1 bits.
  logic [WIDTH-2:0] r_rem;
  logic [WIDTH-1:0] r_shreg;     // dividend bits out at the top, quotient in
  logic [WIDTH-1:0] r_b;         // divisor magnitude
  logic             r_neg_q;     // negate quotient at the final load
  logic             r_neg_r;     // negate remainder at the final load
  logic             r_ovf_pend;  // most-negative / -1 detected at start

  // Operand conditioning: magnitudes plus the sign fix-up decisions.
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg_q;
  logic             w_neg_r;
  logic             w_ovf_case;

`ifdef DIV_SIGNED_EN
  assign w_a_mag    = A[WIDTH-1] ? (~A + c_one) : A;
  assign w_b_mag    = B[WIDTH-1] ? (~B + c_one) : B;
  assign w_neg_q    = A[WIDTH-1] ^ B[WIDTH-1];
  assign w_neg_r    = A[WIDTH-1];
  assign w_ovf_case = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == {WIDTH{1'b1}});
`else
  assign w_a_mag    = A;
  assign w_b_mag    = B;
  assign w_neg_q    = 1'b0;
  assign w_neg_r    = 1'b0;
  assign w_ovf_case = 1'b0;
`endif

  // One iteration step: shift the next dividend bit in, trial-subtract B.
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH:0]   w_add;
  logic             w_borrow;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_q_raw;
  logic [WIDTH-1:0] w_q_out;
  logic [WIDTH-1:0] w_r_out;

  assign w_shift    = {r_rem, r_shreg[WIDTH-1]};
  assign w_add      = {1'b0, w_shift} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_borrow   = ~w_add[WIDTH];
  assign w_next_rem = w_borrow ? w_shift : w_add[WIDTH-1:0];
  assign w_q_raw    = {r_shreg[WIDTH-2:0], ~w_borrow};

  // Sign fix-up folded into the final load so latency matches unsigned.
  assign w_q_out = r_neg_q ? (~w_q_raw + c_one) : w_q_raw;
  assign w_r_out = r_neg_r ? (~w_next_rem + c_one) : w_next_rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_shreg    <= '0;
      r_b        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      Q          <= '0;
      R          <= '0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (r_state)
        c_RUN: begin
          // start is ignored here; operands are not re-sampled.
          r_rem   <= w_next_rem[WIDTH-2:0];
          r_shreg <= w_q_raw;
          r_cnt   <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) begin
            Q       <= w_q_out;
            R       <= w_r_out;
            ovf     <= r_ovf_pend;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= c_DONE;
          end
        end

        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          done <= 1'b0;
          if (r_state == c_DONE) begin
            r_state <= c_IDLE;
          end
          if (start) begin
            dz         <= 1'b0;
            ovf        <= 1'b0;
            r_b        <= w_b_mag;
            r_neg_q    <= w_neg_q;
            r_neg_r    <= w_neg_r;
            r_ovf_pend <= w_ovf_case;
            if (B == '0) begin
              Q       <= {WIDTH{1'b1}};
              R       <= A;
              dz      <= 1'b1;
              done    <= 1'b1;
              r_state <= c_DONE;
            end else begin
              r_cnt   <= c_cnt_init;
              r_rem   <= '0;
              r_shreg <= w_a_mag;
              busy    <= 1'b1;
              r_state <= c_RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_restoring_seq.sv
// ============================================================================
// Module   : tb_div_restoring_seq
// Purpose  : Directed self-checking bench for div_restoring_seq (WIDTH=4).
//            Inputs change on the falling edge and outputs are sampled on the
//            falling edge, away from the active rising edge. Latency is the
//            number of rising edges after the sampling edge until done is seen.
// Options  : DIV_SIGNED_EN - enables the two's complement scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_restoring_seq;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             dz;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  div_restoring_seq #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Q    (Q),
    .R    (R),
    .dz   (dz),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start pulse from the current falling edge; returns at the falling
  // edge right after the sampling edge.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = ~a;   // operands changing after sampling must not matter
    B     = ~b;
  endtask

  // Wait (bounded) for done. lat0 is the edge count already elapsed.
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, Q, R, dz, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b Q=%h R=%h dz=%b ovf=%b, expected all 0",
               busy, done, Q, R, dz, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    launch(4'd13, 4'd3);
    wait_done(0, lat, bc);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    n_checks++;
    if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    n_checks++;
    if ({Q, R, dz, ovf} !== {4'd4, 4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_13_div_3: got Q=%0d R=%0d dz=%b ovf=%b expected Q=4 R=1 dz=0 ovf=0", Q, R, dz, ovf);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy, Q, R} !== {1'b0, 1'b0, 4'd4, 4'd1}) begin
      n_fail++;
      $display("FAIL basic_done_pulse_hold: got done=%b busy=%b Q=%0d R=%0d expected done=0 busy=0 Q=4 R=1",
               done, busy, Q, R);
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    launch(4'd7, 4'd0);
    wait_done(0, lat, bc);
    n_checks++;
    if (lat !== 0 || bc !== 0) begin
      n_fail++;
      $display("FAIL divzero_latency: got lat=%0d busy_cycles=%0d expected 0 and 0", lat, bc);
    end
    n_checks++;
    if ({Q, R, dz} !== {4'hF, 4'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL divzero_result: got Q=%h R=%0d dz=%b expected Q=f R=7 dz=1", Q, R, dz);
    end
    @(negedge clk);
    launch(4'd9, 4'd2);
    wait_done(0, lat, bc);
    n_checks++;
    if ({Q, R, dz, lat} !== {4'd4, 4'd1, 1'b0, 32'd4}) begin
      n_fail++;
      $display("FAIL divzero_recover: got Q=%0d R=%0d dz=%b lat=%0d expected Q=4 R=1 dz=0 lat=4", Q, R, dz, lat);
    end
  endtask

  typedef struct { logic [3:0] a, b, q, r; } vec_t;

  task automatic test_vectors;
    vec_t tbl[5];
    int lat, bc;
    tbl[0] = '{4'd3,  4'd5, 4'd0,  4'd3};
    tbl[1] = '{4'd15, 4'd1, 4'd15, 4'd0};
    tbl[2] = '{4'd8,  4'd9, 4'd0,  4'd8};
    tbl[3] = '{4'd15, 4'd9, 4'd1,  4'd6};
    tbl[4] = '{4'd14, 4'd7, 4'd2,  4'd0};
    foreach (tbl[i]) begin
      @(negedge clk);
      launch(tbl[i].a, tbl[i].b);
      wait_done(0, lat, bc);
      n_checks++;
      if ({Q, R, dz, ovf} !== {tbl[i].q, tbl[i].r, 1'b0, 1'b0} || lat !== 4) begin
        n_fail++;
        $display("FAIL vector_%0d_div_%0d: got Q=%0d R=%0d dz=%b ovf=%b lat=%0d expected Q=%0d R=%0d dz=0 ovf=0 lat=4",
                 tbl[i].a, tbl[i].b, Q, R, dz, ovf, lat, tbl[i].q, tbl[i].r);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    launch(4'd5, 4'd2);
    wait_done(0, lat, bc);
    n_checks++;
    if ({done, Q, R} !== {1'b1, 4'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b Q=%0d R=%0d expected done=1 Q=2 R=1", done, Q, R);
    end
    // Issue the next request in the done cycle itself.
    launch(4'd11, 4'd4);
    n_checks++;
    if ({done, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    wait_done(0, lat, bc);
    n_checks++;
    if ({Q, R, lat} !== {4'd2, 4'd3, 32'd4}) begin
      n_fail++;
      $display("FAIL b2b_second: got Q=%0d R=%0d lat=%0d expected Q=2 R=3 lat=4", Q, R, lat);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    @(negedge clk);
    launch(4'd13, 4'd3);
    @(negedge clk);
    A     = 4'd2;
    B     = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat, bc);
    n_checks++;
    if ({Q, R, lat} !== {4'd4, 4'd1, 32'd4}) begin
      n_fail++;
      $display("FAIL ignore_start_in_run: got Q=%0d R=%0d lat=%0d expected Q=4 R=1 lat=4", Q, R, lat);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    launch(4'd13, 4'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, Q, R, dz, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b Q=%h R=%h dz=%b ovf=%b expected all 0",
               busy, done, Q, R, dz, ovf);
    end
    rst_n = 1'b1;
    seen  = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_abort_no_done: got %0d cycles with done/busy expected 0", seen);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    vec_t tbl[4];
    logic [3:0] exp_ovf;
    logic [3:0] exp_dz;
    int lat, bc;
    tbl[0] = '{4'b1001, 4'd2,    4'b1101, 4'b1111};  // -7 / 2  = -3 r -1
    tbl[1] = '{4'b1000, 4'b1111, 4'b1000, 4'd0};     // -8 / -1 overflows
    tbl[2] = '{4'd7,    4'b1110, 4'b1101, 4'd1};     //  7 / -2 = -3 r 1
    tbl[3] = '{4'b1000, 4'd0,    4'hF,    4'b1000};  // -8 / 0
    exp_ovf = 4'b0010;
    exp_dz  = 4'b1000;
    foreach (tbl[i]) begin
      @(negedge clk);
      launch(tbl[i].a, tbl[i].b);
      wait_done(0, lat, bc);
      n_checks++;
      if ({done, Q, R, ovf, dz} !== {1'b1, tbl[i].q, tbl[i].r, exp_ovf[i], exp_dz[i]}) begin
        n_fail++;
        $display("FAIL signed_%0d: got done=%b Q=%b R=%b ovf=%b dz=%b expected done=1 Q=%b R=%b ovf=%b dz=%b",
                 i, done, Q, R, ovf, dz, tbl[i].q, tbl[i].r, exp_ovf[i], exp_dz[i]);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_div_zero;
    test_vectors;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
`ifdef DIV_SIGNED_EN
    test_signed;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
